// File: rtl/comparador_serial_di.sv
// Bit-serial MSB-first magnitude comparator: one bit per clock, stops at the first
// differing bit and reports A>B / A<B / A==B with the index of the deciding bit.
module comparador_serial_di #(
    parameter  int K  = 5,
    localparam int CW = (K > 1) ? $clog2(K) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [K-1:0]  A,
    input  logic [K-1:0]  B,
    output logic          busy,
    output logic          done,
    output logic          M,
    output logic          N,
    output logic          Z,
    output logic [CW-1:0] P
);

    typedef enum logic [1:0] {IDLE, COMPARE, DONE} state_t;

    state_t        state_q, state_d;
    logic [K-1:0]  a_sh_q, a_sh_d;
    logic [K-1:0]  b_sh_q, b_sh_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] p_q, p_d;
    logic          m_q, m_d, n_q, n_d, z_q, z_d;
    logic          busy_q, busy_d, done_q, done_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            cnt_q   <= '0;
            p_q     <= '0;
            m_q     <= 1'b0;
            n_q     <= 1'b0;
            z_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            m_q     <= m_d;
            n_q     <= n_d;
            z_q     <= z_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // done_d is only raised on the transition into DONE, so done is a one-cycle pulse.
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        m_d     = m_q;
        n_d     = n_q;
        z_d     = z_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d  = A;
                    b_sh_d  = B;
                    cnt_d   = CW'(K - 1);
                    p_d     = '0;
                    m_d     = 1'b0;
                    n_d     = 1'b0;
                    z_d     = 1'b0;
                    busy_d  = 1'b1;
                    state_d = COMPARE;
                end
            end
            COMPARE: begin
                if (a_sh_q[K-1] && !b_sh_q[K-1]) begin
                    m_d     = 1'b1;
                    p_d     = cnt_q;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else if (!a_sh_q[K-1] && b_sh_q[K-1]) begin
                    n_d     = 1'b1;
                    p_d     = cnt_q;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else if (cnt_q == '0) begin
                    z_d     = 1'b1;
                    p_d     = '0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    a_sh_d  = a_sh_q << 1;
                    b_sh_d  = b_sh_q << 1;
                    cnt_d   = cnt_q - 1'b1;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    assign busy = busy_q;
    assign done = done_q;
    assign M    = m_q;
    assign N    = n_q;
    assign Z    = z_q;
    assign P    = p_q;

endmodule
